// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t    : request/wait state of the fetch FSM
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_STEP          : default sequential PC increment in bytes
//   BUBBLE_INSTR     : instruction word presented when nothing is valid
//   align_pc()       : forces a target address onto a word boundary
package instr_fetch_unit_pkg;

    typedef enum logic [0:0] {
        FETCH_REQ  = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] BUBBLE_INSTR     = 32'b0;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// One-entry fetch buffer holding a fetched PC/instruction pair for IF/ID.
// Ports:
//   clk_i        clock, rising edge
//   start_i      asynchronous active-low reset (clears the valid flag)
//   load_i       capture load_pc_i/load_instr_i and mark the entry valid
//   load_pc_i    PC of the instruction being loaded
//   load_instr_i instruction word being loaded
//   clear_i      flush the entry (redirect)
//   consume_i    downstream has taken the entry
//   valid_o      entry is live
//   pc_o         entry PC, 0 when not valid
//   instr_o      entry instruction, bubble when not valid
module instr_fetch_unit_fetch_buffer
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic [31:0] load_instr_i,
    input  logic        clear_i,
    input  logic        consume_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // A load wins over consume/clear so an entry emptied this edge can be refilled.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (clear_i || consume_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload needs no reset: it is never observed while valid_q is low.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            pc_q    <= load_pc_i;
            instr_q <= load_instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = valid_q ? pc_q    : 32'b0;
    assign instr_o = valid_q ? instr_q : BUBBLE_INSTR;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues one outstanding request at a time to instruction
// memory, and parks the returned word in a one-entry fetch buffer.
// Ports:
//   clk_i          clock, rising edge
//   start_i        asynchronous active-low reset
//   stall_i        hazard stall: IF/ID is holding, buffer is not consumed
//   redirect_i     taken branch/jump from ID (1-cycle pulse)
//   redirect_pc_i  redirect target, low two bits ignored
//   imem_req_o     request valid
//   imem_addr_o    request address
//   imem_ready_i   memory accepts the request this cycle
//   imem_rvalid_i  response valid (one per accepted request)
//   imem_rdata_i   response instruction word
//   PC_o           PC of presented instruction (0 when not valid)
//   instr_o        presented instruction (bubble when not valid)
//   valid_o        fetch buffer holds a live instruction
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = instr_fetch_unit_pkg::PC_STEP
)(
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  fb_pc_q;
    logic         drop_q;

    logic         fb_valid;
    logic         consume;
    logic         fb_free;
    logic         accept;
    logic         fb_load;

    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        fb_load    = 1'b0;
        consume    = fb_valid & ~stall_i & ~redirect_i;
        fb_free    = ~fb_valid | consume;

        case (state_q)
            FETCH_REQ: begin
                // start_i gate keeps the request low while reset is held.
                imem_req_o = start_i & fb_free & ~redirect_i;
                if (imem_req_o && imem_ready_i) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    // A response belonging to a path abandoned by a redirect
                    // (now or earlier) is thrown away.
                    fb_load = ~drop_q & ~redirect_i;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        accept = imem_req_o & imem_ready_i;
    end

    assign imem_addr_o = pc_q;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (redirect_i) begin
                pc_q <= align_pc(redirect_pc_i);
            end else if (accept) begin
                pc_q <= pc_q + PC_STEP;
            end

            // drop_q marks the single in-flight response as stale.
            if (state_q == FETCH_WAIT && imem_rvalid_i) begin
                drop_q <= 1'b0;
            end else if (state_q == FETCH_WAIT && redirect_i) begin
                drop_q <= 1'b1;
            end
        end
    end

    // PC of the outstanding request, paired with its response on return.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fb_pc_q <= pc_q;
        end
    end

    instr_fetch_unit_fetch_buffer u_fetch_buffer (
        .clk_i        (clk_i),
        .start_i      (start_i),
        .load_i       (fb_load),
        .load_pc_i    (fb_pc_q),
        .load_instr_i (imem_rdata_i),
        .clear_i      (redirect_i),
        .consume_i    (consume),
        .valid_o      (fb_valid),
        .pc_o         (PC_o),
        .instr_o      (instr_o)
    );

    assign valid_o = fb_valid;

endmodule
